// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- serial receive stage of the UART.
//
// Turns the asynchronous RX_DSER pin into parallel words for the AXI4-Lite
// wrapper. Framing: one start bit, DATA_BITS data bits LSB first, optional
// even-parity bit, one stop bit. Each bit is sampled at its middle using a
// clock-cycle counter. Frames with a bad stop bit (or bad parity) are flagged
// and never delivered as data.
//
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit
// between the last data bit and the stop bit. Without it RX_PERR stays 0.
//
// Parameters:
//   CLOCK_FREQUENCY  CLK frequency in Hz
//   BAUD_RATE        line rate in bit/s (CLOCK_FREQUENCY/BAUD_RATE >= 4)
//   DATA_BITS        data bits per frame, 5..9
//
// Ports:
//   CLK      in   system clock, single domain
//   NRST     in   synchronous active-low reset
//   RX_DSER  in   asynchronous serial input, idle high
//   RX_DO    out  last correctly framed word, stable between RX_DRDY pulses
//   RX_DRDY  out  one-cycle pulse: RX_DO updated this cycle
//   RX_FERR  out  one-cycle pulse: stop bit sampled low, frame dropped
//   RX_PERR  out  one-cycle pulse: parity mismatch, frame dropped
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115_200,
  parameter int DATA_BITS       = 8
) (
  input  logic                 CLK,
  input  logic                 NRST,
  input  logic                 RX_DSER,
  output logic [DATA_BITS-1:0] RX_DO,
  output logic                 RX_DRDY,
  output logic                 RX_FERR,
  output logic                 RX_PERR
);

  localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 4) begin : g_bad_ratio
    $error("uart_rx: CLOCK_FREQUENCY/BAUD_RATE must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_rx: DATA_BITS must be in 5..9");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rx_s;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_err;
  logic                 tick;
  logic                 drdy_nxt, ferr_nxt, perr_nxt;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours, whatever the order.
      rx_meta <= RX_DSER;
      rx_s    <= rx_meta;
    end
  end

  // START waits half a bit to land mid start bit; later bits are a full
  // bit apart, which keeps every sample centred.
  assign tick = (state == S_START) ? (cnt == CNT_W'(HALF - 1))
                                   : (cnt == CNT_W'(CLKS_PER_BIT - 1));

  // State register.
  always_ff @(posedge CLK) begin
    if (!NRST) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_nxt
    // unassigned and a latch cannot be inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (!rx_s) state_nxt = S_START;
      S_START: if (tick)  state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:
        if (tick && bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (tick) state_nxt = S_STOP;
`endif
      // Entering IDLE on the stop sample lets a back-to-back start edge be
      // seen with no dead cycle.
      S_STOP:  if (tick) state_nxt = rx_s ? S_IDLE : S_BREAK;
      // A line held low after a framing error must not start a new frame.
      S_BREAK: if (rx_s)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: status pulses are decided on the stop-bit sample and
  // registered, so they are one cycle wide and mutually exclusive.
  always_comb begin
    drdy_nxt = 1'b0;
    ferr_nxt = 1'b0;
    perr_nxt = 1'b0;
    if (state == S_STOP && tick) begin
      if (!rx_s)          ferr_nxt = 1'b1;  // stop error wins over parity
      else if (parity_err) perr_nxt = 1'b1;
      else                 drdy_nxt = 1'b1;
    end
  end

  // Bit timing, shift register and registered outputs.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift_q <= '0;
      RX_DO   <= '0;
      RX_DRDY <= 1'b0;
      RX_FERR <= 1'b0;
      RX_PERR <= 1'b0;
    end else begin
      if (state == S_IDLE || state == S_BREAK || tick) cnt <= '0;
      else                                             cnt <= cnt + CNT_W'(1);

      if (state != S_DATA)  bit_idx <= '0;
      else if (tick)        bit_idx <= bit_idx + IDX_W'(1);

      if (state == S_DATA && tick) shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};

      if (drdy_nxt) RX_DO <= shift_q;
      RX_DRDY <= drdy_nxt;
      RX_FERR <= ferr_nxt;
      RX_PERR <= perr_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: XOR of the data bits and the parity bit must be 0.
  always_ff @(posedge CLK) begin
    if (!NRST)                         parity_err <= 1'b0;
    else if (state == S_PARITY && tick) parity_err <= ^{shift_q, rx_s};
    else if (state == S_IDLE)          parity_err <= 1'b0;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
